// File: rtl/cpu_mem_line_controller.sv
// ---------------------------------------------------------------------------
// cpu_mem_line_controller
//   Main-memory model/controller at the slave end of the line-granular memory
//   request bus. Accepts one line read or line write at a time, services it
//   from internal line storage after a fixed latency, then returns a one-cycle
//   completion pulse. Read data is registered and held until the next read
//   completes.
//
// Ports
//   clk           in   1               system clock
//   reset         in   1               asynchronous, active-high reset
//   req_read      in   1               line read request
//   req_write     in   1               line write request
//   req_data      in   LINE_WIDTH      line to write
//   req_addr      in   MEM_ADDR_WIDTH  line address (low bits index storage)
//   resp_valid    out  1               one-cycle completion pulse
//   resp_data     out  LINE_WIDTH      last read line
//   busy          out  1               transaction in flight
//   protocol_err  out  1               sticky: read and write sampled together
// ---------------------------------------------------------------------------
module cpu_mem_line_controller #(
  parameter int LINE_WIDTH     = 64,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int MEM_DEPTH      = 256,
  parameter int MEM_LATENCY    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_read,
  input  logic                      req_write,
  input  logic [LINE_WIDTH-1:0]     req_data,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
  output logic                      resp_valid,
  output logic [LINE_WIDTH-1:0]     resp_data,
  output logic                      busy,
  output logic                      protocol_err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     count;
  logic                 op_write;
  logic [IDX_W-1:0]     op_idx;
  logic [LINE_WIDTH-1:0] op_data;
  logic [LINE_WIDTH-1:0] mem [MEM_DEPTH];

  logic req_any;
  logic commit;

  // Upper address bits alias onto the same storage lines by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[MEM_ADDR_WIDTH-1:IDX_W];

  assign req_any    = req_read | req_write;
  // The BUSY->DONE edge is the single point where storage is touched.
  assign commit     = (state == BUSY) && (count == '0);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = BUSY;
      BUSY:    if (count == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      op_write     <= 1'b0;
      op_idx       <= '0;
      op_data      <= '0;
      resp_data    <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            // Write wins when both are asserted; the read is dropped.
            op_write <= req_write;
            op_idx   <= req_addr[IDX_W-1:0];
            op_data  <= req_data;
            count    <= CNT_W'(MEM_LATENCY - 2);
            if (req_read && req_write) protocol_err <= 1'b1;
          end
        end
        BUSY: begin
          if (count != '0)   count     <= count - 1'b1;
          else if (!op_write) resp_data <= mem[op_idx];
        end
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset so it maps onto plain RAM and keeps its
  // contents across reset; an aborted write never reaches commit because
  // reset forces the FSM back to IDLE.
  always_ff @(posedge clk) begin
    if (commit && op_write) mem[op_idx] <= op_data;
  end

endmodule

// File: tb/tb_cpu_mem_line_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_line_controller
//   Self-checking bench: a directed vector table, hand-written multi-cycle
//   sequences (address change while busy, reset mid-write) and randomized
//   transactions compared against a line-array reference model.
// ---------------------------------------------------------------------------
module tb_cpu_mem_line_controller;

  localparam int LW    = 64;
  localparam int AW    = 12;
  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_read;
  logic          req_write;
  logic [LW-1:0] req_data;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic [LW-1:0] resp_data;
  logic          busy;
  logic          protocol_err;

  cpu_mem_line_controller #(
    .LINE_WIDTH(LW), .MEM_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write),
    .req_data(req_data), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: storage lines, last read line, sticky error.
  logic [LW-1:0] ref_mem   [DEPTH];
  bit            ref_known [DEPTH];
  logic [LW-1:0] ref_resp;
  bit            ref_resp_known;
  bit            ref_perr;

  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One complete transaction. Inputs change and outputs are sampled on the
  // falling edge. Optionally changes addr/data two cycles into the wait.
  task automatic txn(input bit rd, input bit wr,
                     input logic [AW-1:0] addr, input logic [LW-1:0] data,
                     input bit chg, input logic [AW-1:0] addr2, input logic [LW-1:0] data2,
                     output int resp_cyc);
    int lat;
    int busy_cnt;
    bit seen;
    int idx;
    @(negedge clk);
    check("idle_resp_valid", LW'(resp_valid), '0);
    check("idle_busy", LW'(busy), '0);
    req_read  = rd;
    req_write = wr;
    req_addr  = addr;
    req_data  = data;
    lat = 0; busy_cnt = 0; seen = 0; resp_cyc = -1;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (chg && lat == 2) begin
        req_addr = addr2;
        req_data = data2;
      end
      if (resp_valid) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: no resp_valid within %0d cycles", lat);
    end else begin
      resp_cyc = cyc;
      check("latency", LW'(lat), LW'(LAT));
      check("busy_cycles", LW'(busy_cnt), LW'(LAT));
    end
    req_read  = 1'b0;
    req_write = 1'b0;
    // Model update from the transaction's original request.
    idx = int'(addr) % DEPTH;
    if (wr) begin
      ref_mem[idx]   = data;
      ref_known[idx] = 1'b1;
      if (rd) ref_perr = 1'b1;
    end else if (rd) begin
      ref_resp       = ref_mem[idx];
      ref_resp_known = ref_known[idx];
    end
    if (ref_resp_known) check("model_resp_data", resp_data, ref_resp);
    check("model_protocol_err", LW'(protocol_err), LW'(ref_perr));
  endtask

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    logic [LW-1:0] exp_data;
    bit            exp_perr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int rc;
    int prev_rc;
    int pulses;
    logic [LW-1:0] a5, x5a, c3, v7;
    a5  = {8{8'hA5}};
    x5a = {8{8'h5A}};
    c3  = {8{8'hC3}};
    v7  = 64'h0123_4567_89AB_CDEF;

    vecs[0] = '{rd: 0, wr: 1, addr: 12'd3,   data: a5,  exp_data: '0,  exp_perr: 0};
    vecs[1] = '{rd: 1, wr: 0, addr: 12'd3,   data: '0,  exp_data: a5,  exp_perr: 0};
    vecs[2] = '{rd: 0, wr: 1, addr: 12'd259, data: x5a, exp_data: a5,  exp_perr: 0};
    vecs[3] = '{rd: 1, wr: 0, addr: 12'd3,   data: '0,  exp_data: x5a, exp_perr: 0};
    vecs[4] = '{rd: 0, wr: 1, addr: 12'd7,   data: v7,  exp_data: x5a, exp_perr: 0};
    vecs[5] = '{rd: 1, wr: 0, addr: 12'd7,   data: '0,  exp_data: v7,  exp_perr: 0};
    vecs[6] = '{rd: 1, wr: 1, addr: 12'd9,   data: c3,  exp_data: v7,  exp_perr: 1};
    vecs[7] = '{rd: 1, wr: 0, addr: 12'd9,   data: '0,  exp_data: c3,  exp_perr: 1};

    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
    ref_resp = '0; ref_resp_known = 1'b1; ref_perr = 1'b0;

    reset = 1'b1; req_read = 1'b0; req_write = 1'b0; req_data = '0; req_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_resp_valid", LW'(resp_valid), '0);
    check("reset_busy", LW'(busy), '0);
    check("reset_resp_data", resp_data, '0);
    check("reset_protocol_err", LW'(protocol_err), '0);
    reset = 1'b0;

    // Directed table, issued back to back with zero bubble.
    prev_rc = 0;
    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, '0, '0, rc);
      check($sformatf("vec%0d_resp_data", i), resp_data, vecs[i].exp_data);
      check($sformatf("vec%0d_protocol_err", i), LW'(protocol_err), LW'(vecs[i].exp_perr));
      if (i > 0) check($sformatf("vec%0d_gap", i), LW'(rc - prev_rc), LW'(LAT + 1));
      prev_rc = rc;
    end

    // Address/data change while busy is ignored.
    txn(0, 1, 12'd21, 64'h2121_2121_0000_0021, 1'b0, '0, '0, rc);
    txn(0, 1, 12'd20, 64'h2020_2020_0000_0020, 1'b1, 12'd21, 64'hDEAD_BEEF_DEAD_BEEF, rc);
    txn(1, 0, 12'd20, '0, 1'b0, '0, '0, rc);
    check("busy_chg_addr20", resp_data, 64'h2020_2020_0000_0020);
    txn(1, 0, 12'd21, '0, 1'b0, '0, '0, rc);
    check("busy_chg_addr21", resp_data, 64'h2121_2121_0000_0021);

    // Randomized traffic against the model.
    for (int n = 0; n < 200; n++) begin
      int r;
      bit rd, wr;
      r  = $urandom_range(0, 9);
      wr = (r <= 3) || (r == 9);
      rd = (r >= 4);
      txn(rd, wr, AW'($urandom), {$urandom, $urandom}, 1'b0, '0, '0, rc);
    end

    // Reset two cycles into a write aborts it.
    txn(0, 1, 12'd30, 64'h3030_3030_3030_3030, 1'b0, '0, '0, rc);
    @(negedge clk);
    req_write = 1'b1; req_addr = 12'd30; req_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_resp_valid", LW'(resp_valid), '0);
    check("abort_busy", LW'(busy), '0);
    check("abort_resp_data", resp_data, '0);
    check("abort_protocol_err", LW'(protocol_err), '0);
    req_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort_no_pulse", LW'(pulses), '0);
    ref_resp = '0; ref_resp_known = 1'b1; ref_perr = 1'b0;
    txn(1, 0, 12'd30, '0, 1'b0, '0, '0, rc);
    check("abort_prior_contents", resp_data, 64'h3030_3030_3030_3030);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
